// File: rtl/sdram_client_pkg.sv
// Shared types and helpers for SDRAM client ports that use the toggle req/ack handshake.
package sdram_client_pkg;

  localparam int unsigned AW_DEF = 23;
  localparam int unsigned DW     = 16;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_DEMAND = 2'd2,
    ST_PF     = 2'd3
  } state_t;

  // A request is outstanding whenever the two toggle levels differ.
  function automatic logic pending(input logic req, input logic ack);
    return req ^ ack;
  endfunction

endpackage

// File: rtl/toggle_req_initiator.sv
// Toggle-style request initiator: owns the req level and request address and
// reports completion of its own requests.
module toggle_req_initiator
  import sdram_client_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync,
  input  logic          issue,
  input  logic [AW-1:0] issue_a,
  input  logic          ack,
  output logic          req,
  output logic [AW-1:0] addr,
  output logic          pending_c,
  output logic          done_c
);

  logic busy;

  assign pending_c = pending(req, ack);
  // busy restricts completion to requests this block issued, so a stray ack is ignored
  assign done_c    = busy & ~pending_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req  <= 1'b0;
      addr <= '0;
      busy <= 1'b0;
    end else begin
      if (sync) begin
        req <= ack;
      end else if (issue) begin
        req  <= ~req;
        addr <= issue_a;
      end
      busy <= issue | (busy & pending_c);
    end
  end

endmodule

// File: rtl/sdram_rom_prefetch.sv
// ROM read client: turns a held CPU strobe into toggle requests, serves repeats
// from a one-word line and prefetches the next word after each fill.
module sdram_rom_prefetch
  import sdram_client_pkg::*;
#(
  parameter bit          PREFETCH = 1'b1,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_a,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ack,
  input  logic          invalidate,
  output logic          romrd_req,
  input  logic          romrd_ack,
  output logic [AW-1:0] romrd_a,
  input  logic [DW-1:0] romrd_q
);

  state_t        state, state_nx;
  logic          line_valid, line_valid_nx;
  logic [AW-1:0] line_tag, line_tag_nx;
  logic [DW-1:0] line_data, line_data_nx;
  logic          pf_discard, pf_discard_nx;
  logic          served, served_nx;
  logic [DW-1:0] cpu_q_nx;
  logic          cpu_ack_nx;

  logic          issue_c, sync_c, pending_c, done_c, creq_c, discard_c;
  logic [AW-1:0] issue_a_c;

  toggle_req_initiator #(.AW(AW)) u_init (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync_c),
    .issue     (issue_c),
    .issue_a   (issue_a_c),
    .ack       (romrd_ack),
    .req       (romrd_req),
    .addr      (romrd_a),
    .pending_c (pending_c),
    .done_c    (done_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SYNC;
      cpu_q      <= '0;
      cpu_ack    <= 1'b0;
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
      pf_discard <= 1'b0;
      served     <= 1'b0;
    end else begin
      state      <= state_nx;
      cpu_q      <= cpu_q_nx;
      cpu_ack    <= cpu_ack_nx;
      line_valid <= line_valid_nx;
      line_tag   <= line_tag_nx;
      line_data  <= line_data_nx;
      pf_discard <= pf_discard_nx;
      served     <= served_nx;
    end
  end

  // served blocks a second ack until the CPU has dropped its strobe
  assign creq_c    = cpu_req & ~served;
  assign discard_c = pf_discard | invalidate;

  always_comb begin
    state_nx      = state;
    cpu_q_nx      = cpu_q;
    cpu_ack_nx    = 1'b0;
    line_valid_nx = line_valid & ~invalidate;
    line_tag_nx   = line_tag;
    line_data_nx  = line_data;
    pf_discard_nx = pf_discard;
    served_nx     = served & cpu_req;
    issue_c       = 1'b0;
    issue_a_c     = romrd_a;
    sync_c        = 1'b0;

    case (state)
      ST_SYNC: begin
        sync_c   = 1'b1;
        state_nx = ST_IDLE;
      end

      ST_IDLE: begin
        if (creq_c) begin
          if (line_valid && !invalidate && line_tag == cpu_a) begin
            cpu_q_nx   = line_data;
            cpu_ack_nx = 1'b1;
            served_nx  = 1'b1;
          end else if (!pending_c) begin
            issue_c       = 1'b1;
            issue_a_c     = cpu_a;
            pf_discard_nx = 1'b0;
            state_nx      = ST_DEMAND;
          end
        end
      end

      ST_DEMAND: begin
        if (invalidate) pf_discard_nx = 1'b1;
        if (done_c) begin
          cpu_q_nx      = romrd_q;
          cpu_ack_nx    = 1'b1;
          served_nx     = 1'b1;
          pf_discard_nx = 1'b0;
          state_nx      = ST_IDLE;
          // stale-by-invalidate data goes to the CPU but never into the line
          if (!discard_c) begin
            line_valid_nx = 1'b1;
            line_tag_nx   = romrd_a;
            line_data_nx  = romrd_q;
            if (PREFETCH) begin
              issue_c   = 1'b1;
              issue_a_c = romrd_a + AW'(1);
              state_nx  = ST_PF;
            end
          end
        end
      end

      ST_PF: begin
        if (invalidate) pf_discard_nx = 1'b1;
        if (done_c) begin
          pf_discard_nx = 1'b0;
          if (!discard_c) begin
            line_valid_nx = 1'b1;
            line_tag_nx   = romrd_a;
            line_data_nx  = romrd_q;
          end
          if (creq_c && cpu_a == romrd_a && !discard_c) begin
            cpu_q_nx   = romrd_q;
            cpu_ack_nx = 1'b1;
            served_nx  = 1'b1;
            issue_c    = 1'b1;
            issue_a_c  = romrd_a + AW'(1);
          end else if (creq_c) begin
            issue_c   = 1'b1;
            issue_a_c = cpu_a;
            state_nx  = ST_DEMAND;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end

      default: state_nx = ST_SYNC;
    endcase
  end

endmodule
